// File: rtl/iter_divider_pkg.sv
// Shared definitions for the iterative restoring divider: operand width,
// fixed latency and the controller state encoding.
package iter_divider_pkg;

   localparam int DIV_WIDTH = 32;

   function automatic int div_latency(input int width);
      return width + 1;
   endfunction

   localparam int DIV_LATENCY = div_latency(DIV_WIDTH);

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_BUSY = 2'd1,
      ST_DONE = 2'd2
   } div_state_e;

endpackage

// File: rtl/iter_divider_if.sv
// Operand/result stream bundle between the EX-stage multiply/divide unit
// (master) and the divider (slave).
interface iter_divider_if
   import iter_divider_pkg::*;
#(
   parameter int WIDTH = DIV_WIDTH
);

   logic [WIDTH-1:0]   s_axis_dividend_tdata;
   logic               s_axis_dividend_tvalid;
   logic [WIDTH-1:0]   s_axis_divisor_tdata;
   logic               s_axis_divisor_tvalid;
   logic               s_axis_tready;
   logic [2*WIDTH-1:0] m_axis_dout_tdata;
   logic               m_axis_dout_tvalid;
   logic               m_axis_dout_divzero;

   modport master (
      output s_axis_dividend_tdata, s_axis_dividend_tvalid,
      output s_axis_divisor_tdata, s_axis_divisor_tvalid,
      input  s_axis_tready,
      input  m_axis_dout_tdata, m_axis_dout_tvalid, m_axis_dout_divzero
   );

   modport slave (
      input  s_axis_dividend_tdata, s_axis_dividend_tvalid,
      input  s_axis_divisor_tdata, s_axis_divisor_tvalid,
      output s_axis_tready,
      output m_axis_dout_tdata, m_axis_dout_tvalid, m_axis_dout_divzero
   );

endinterface

// File: rtl/iter_divider_div_step.sv
// One restoring-division step: shift {remainder, dividend} left by one and
// keep the trial difference when the divisor fits.
module div_step
   import iter_divider_pkg::*;
#(
   parameter int WIDTH = DIV_WIDTH
) (
   input  logic [WIDTH-1:0] rem_i,
   input  logic [WIDTH-1:0] dvd_i,
   input  logic [WIDTH-1:0] dvs_i,
   output logic [WIDTH-1:0] rem_o,
   output logic [WIDTH-1:0] dvd_o,
   output logic             q_bit_o
);

   logic [WIDTH:0] rem_shift;
   logic [WIDTH:0] diff;
   logic           borrow;

   // NOTE: every output and temporary is assigned on every path through this
   // block, so it stays purely combinational and no latch is inferred.
   always_comb begin
      rem_shift      = {rem_i, dvd_i[WIDTH-1]};
      {borrow, diff} = {1'b0, rem_shift} - {2'b00, dvs_i};
      q_bit_o        = ~borrow;
      rem_o          = q_bit_o ? WIDTH'(diff) : WIDTH'(rem_shift);
      // lsb left clear; the caller inserts the quotient bit there
      dvd_o          = {dvd_i[WIDTH-2:0], 1'b0};
   end

endmodule

// File: rtl/iter_divider.sv
// Fixed-latency unsigned divider: one restoring step per cycle, quotient
// collected in the dividend register, result presented as a one-cycle pulse.
module iter_divider
   import iter_divider_pkg::*;
#(
   parameter int WIDTH   = DIV_WIDTH,
   parameter int LATENCY = div_latency(WIDTH)
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          flush,
   iter_divider_if.slave bus
);

   localparam int CNT_W = $clog2(LATENCY);

   div_state_e         state_q;
   logic [WIDTH-1:0]   rem_q;
   logic [WIDTH-1:0]   dvd_q;
   logic [WIDTH-1:0]   dvs_q;
   logic [CNT_W-1:0]   cnt_q;
   logic [2*WIDTH-1:0] tdata_q;
   logic               tvalid_q;
   logic               divzero_q;

   logic [WIDTH-1:0]   rem_d;
   logic [WIDTH-1:0]   dvd_d;
   logic [WIDTH-1:0]   quo_d;
   logic               q_bit;
   logic               operands_valid;

   div_step #(.WIDTH(WIDTH)) u_step (
      .rem_i   (rem_q),
      .dvd_i   (dvd_q),
      .dvs_i   (dvs_q),
      .rem_o   (rem_d),
      .dvd_o   (dvd_d),
      .q_bit_o (q_bit)
   );

   assign quo_d          = dvd_d | WIDTH'(q_bit);
   assign operands_valid = bus.s_axis_dividend_tvalid & bus.s_axis_divisor_tvalid;

   // NOTE: all state is updated with non-blocking assignments so every register
   // samples pre-edge values, independent of statement order.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= ST_IDLE;
         rem_q     <= '0;
         dvd_q     <= '0;
         dvs_q     <= '0;
         cnt_q     <= '0;
         tdata_q   <= '0;
         tvalid_q  <= 1'b0;
         divzero_q <= 1'b0;
      end else begin
         tvalid_q <= 1'b0;
         if (flush) begin
            state_q <= ST_IDLE;
         end else begin
            unique case (state_q)
               ST_IDLE: begin
                  if (operands_valid) begin
                     dvd_q   <= bus.s_axis_dividend_tdata;
                     dvs_q   <= bus.s_axis_divisor_tdata;
                     rem_q   <= '0;
                     cnt_q   <= CNT_W'(LATENCY - 1);
                     state_q <= ST_BUSY;
                  end
               end
               ST_BUSY: begin
                  rem_q <= rem_d;
                  dvd_q <= quo_d;
                  cnt_q <= cnt_q - CNT_W'(1);
                  // a zero divisor never borrows, so it naturally yields all-ones / dividend
                  if (cnt_q == CNT_W'(1)) begin
                     state_q   <= ST_DONE;
                     tvalid_q  <= 1'b1;
                     tdata_q   <= {quo_d, rem_d};
                     divzero_q <= (dvs_q == '0);
                  end
               end
               ST_DONE: state_q <= ST_IDLE;
               default: state_q <= ST_IDLE;
            endcase
         end
      end
   end

   assign bus.s_axis_tready       = (state_q == ST_IDLE);
   assign bus.m_axis_dout_tdata   = tdata_q;
   assign bus.m_axis_dout_tvalid  = tvalid_q;
   assign bus.m_axis_dout_divzero = divzero_q;

endmodule

// File: tb/tb_iter_divider.sv
// Randomized scoreboard bench for iter_divider: a timing-level model predicts
// when each result appears and plain '/' and '%' predict its value.
`timescale 1ns/1ps
module tb_iter_divider;
   import iter_divider_pkg::*;

   localparam int W   = DIV_WIDTH;
   localparam int DW  = 2 * W;
   localparam int LAT = DIV_LATENCY;

   typedef struct {
      int          vis_edge;
      logic [DW-1:0] tdata;
      logic        divzero;
   } exp_t;

   logic clk   = 1'b0;
   logic rst   = 1'b1;
   logic flush = 1'b0;

   iter_divider_if #(.WIDTH(W)) bus ();

   iter_divider #(.WIDTH(W), .LATENCY(LAT)) dut (
      .clk   (clk),
      .rst   (rst),
      .flush (flush),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   int edge_cnt = 0;
   always @(posedge clk) edge_cnt <= edge_cnt + 1;

   exp_t sb_q[$];
   int   free_edge  = 0;
   bit   model_live = 1'b0;
   bit   mon_en     = 1'b0;
   int   checks     = 0;
   int   errors     = 0;

   task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s near edge %0d: got %h, expected %h", name, edge_cnt, act, req);
      end
   endtask

   function automatic logic [DW-1:0] ref_div(input logic [W-1:0] a, input logic [W-1:0] b);
      if (b == '0) return {{W{1'b1}}, a};
      return {a / b, a % b};
   endfunction

   function automatic logic [W-1:0] rand_opnd(input bit is_divisor);
      case ($urandom_range(0, 5))
         0:       return is_divisor ? '0 : W'($urandom_range(0, 15));
         1:       return W'($urandom_range(1, 255));
         2:       return {W{1'b1}};
         default: return W'($urandom());
      endcase
   endfunction

   // Drive inputs for the next rising edge and advance the timing model:
   // an accept at edge n shows its result after edge n+LAT-1 and frees the
   // unit for edge n+LAT+1; flush/rst at edge n kills anything not yet shown.
   task automatic drive(input logic dv, input logic sv, input logic [W-1:0] a,
                        input logic [W-1:0] b, input logic fl, input logic rs);
      int n;
      @(negedge clk);
      bus.s_axis_dividend_tvalid = dv;
      bus.s_axis_divisor_tvalid  = sv;
      bus.s_axis_dividend_tdata  = a;
      bus.s_axis_divisor_tdata   = b;
      flush = fl;
      rst   = rs;
      n = edge_cnt;
      if (model_live) check("tready", DW'(bus.s_axis_tready), DW'(n >= free_edge));
      if (rs || fl) begin
         while (sb_q.size() > 0 && sb_q[$].vis_edge >= n) void'(sb_q.pop_back());
         free_edge  = n + 1;
         model_live = 1'b1;
      end else if (model_live && n >= free_edge && dv && sv) begin
         sb_q.push_back('{n + LAT - 1, ref_div(a, b), (b == '0)});
         free_edge = n + LAT + 1;
      end
   endtask

   task automatic idle();
      drive(1'b0, 1'b0, W'($urandom()), W'($urandom()), 1'b0, 1'b0);
   endtask

   task automatic op(input logic [W-1:0] a, input logic [W-1:0] b);
      drive(1'b1, 1'b1, a, b, 1'b0, 1'b0);
      repeat (LAT + 1) idle();
   endtask

   task automatic check_reset_outputs(input string tag);
      check({tag, "_tvalid"},  DW'(bus.m_axis_dout_tvalid), '0);
      check({tag, "_divzero"}, DW'(bus.m_axis_dout_divzero), '0);
      check({tag, "_tdata"},   bus.m_axis_dout_tdata, '0);
      check({tag, "_tready"},  DW'(bus.s_axis_tready), DW'(1));
   endtask

   // Monitor: compares every presented result against the scoreboard head.
   initial begin
      int vis;
      forever begin
         @(negedge clk);
         if (mon_en) begin
            vis = edge_cnt - 1;
            while (sb_q.size() > 0 && sb_q[0].vis_edge < vis) begin
               checks++;
               errors++;
               $display("FAIL missing_result: no tvalid after edge %0d, expected tdata %h",
                        sb_q[0].vis_edge, sb_q[0].tdata);
               void'(sb_q.pop_front());
            end
            if (bus.m_axis_dout_tvalid !== 1'b0) begin
               if (sb_q.size() > 0 && sb_q[0].vis_edge == vis && bus.m_axis_dout_tvalid === 1'b1) begin
                  check("result_tdata", bus.m_axis_dout_tdata, sb_q[0].tdata);
                  check("result_divzero", DW'(bus.m_axis_dout_divzero), DW'(sb_q[0].divzero));
                  void'(sb_q.pop_front());
               end else begin
                  checks++;
                  errors++;
                  $display("FAIL unexpected_tvalid after edge %0d: tvalid %b, expected 0",
                           vis, bus.m_axis_dout_tvalid);
               end
            end
         end
      end
   end

   initial begin
      bus.s_axis_dividend_tvalid = 1'b0;
      bus.s_axis_divisor_tvalid  = 1'b0;
      bus.s_axis_dividend_tdata  = '0;
      bus.s_axis_divisor_tdata   = '0;

      repeat (3) drive(1'b0, 1'b0, '0, '0, 1'b0, 1'b1);
      idle();
      check_reset_outputs("reset");
      mon_en = 1'b1;

      // corner operands
      op(32'd100, 32'd7);
      op(32'hFFFF_FFFF, 32'd1);
      op(32'h8000_0000, 32'hFFFF_FFFF);
      op(32'h1234_5678, 32'd0);
      op(32'd0, 32'd5);
      op(32'd6, 32'hFFFF_FFFF);

      // flush mid-operation; flush beats a valid pair in the same cycle
      drive(1'b1, 1'b1, 32'd100, 32'd7, 1'b0, 1'b0);
      repeat (9) idle();
      drive(1'b1, 1'b1, 32'd9, 32'd3, 1'b1, 1'b0);
      drive(1'b1, 1'b1, 32'd9, 32'd3, 1'b0, 1'b0);
      repeat (LAT + 1) idle();

      // lone tvalids are ignored; new pairs while busy are ignored
      repeat (5) drive(1'b1, 1'b0, rand_opnd(1'b0), rand_opnd(1'b1), 1'b0, 1'b0);
      repeat (3) drive(1'b0, 1'b1, rand_opnd(1'b0), rand_opnd(1'b1), 1'b0, 1'b0);
      drive(1'b1, 1'b1, 32'd1000, 32'd13, 1'b0, 1'b0);
      repeat (10) drive(1'b1, 1'b1, rand_opnd(1'b0), rand_opnd(1'b1), 1'b0, 1'b0);
      repeat (LAT - 8) idle();

      // continuously offered pairs exercise the earliest re-accept
      repeat (3 * LAT) drive(1'b1, 1'b1, rand_opnd(1'b0), rand_opnd(1'b1), 1'b0, 1'b0);
      repeat (LAT + 1) idle();

      // reset 20 cycles into an operation
      drive(1'b1, 1'b1, 32'd100, 32'd7, 1'b0, 1'b0);
      repeat (19) idle();
      drive(1'b0, 1'b0, '0, '0, 1'b0, 1'b1);
      idle();
      check_reset_outputs("midop_reset");
      repeat (LAT + 1) idle();

      // random traffic with occasional flush and reset
      repeat (3000) begin
         drive($urandom_range(0, 3) != 0, $urandom_range(0, 3) != 0,
               rand_opnd(1'b0), rand_opnd(1'b1),
               $urandom_range(0, 99) == 0, $urandom_range(0, 499) == 0);
      end

      repeat (LAT + 2) idle();
      check("scoreboard_drained", DW'(sb_q.size()), '0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/iter_divider.md
ITER_DIVIDER -- requirements
Module: iter_divider

Interface
REQ-001 Parameter: WIDTH, 32, operand width in bits.
REQ-002 Parameter: LATENCY, 33, cycles from accept to result valid; fixed at WIDTH+1.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst  input  1  synchronous, active-high reset.
REQ-005 flush  input  1  synchronous abort of any operation in progress.
REQ-006 s_axis_dividend_tdata  input  WIDTH  unsigned dividend.
REQ-007 s_axis_dividend_tvalid  input  1  dividend valid.
REQ-008 s_axis_divisor_tdata  input  WIDTH  unsigned divisor.
REQ-009 s_axis_divisor_tvalid  input  1  divisor valid.
REQ-010 s_axis_tready  output  1  high when a new operation can be accepted.
REQ-011 m_axis_dout_tdata  output  2*WIDTH  {quotient, remainder}; quotient in upper half.
REQ-012 m_axis_dout_tvalid  output  1  one-cycle pulse, result valid; no backpressure.
REQ-013 m_axis_dout_divzero  output  1  divisor was zero; qualified by m_axis_dout_tvalid.

Function
REQ-014 States SHALL be IDLE, BUSY, DONE; s_axis_tready SHALL equal (state == IDLE).
REQ-015 Accept SHALL occur on an edge where state is IDLE and both tvalids are high; one tvalid alone SHALL be ignored.
REQ-016 On accept: capture dividend and divisor, clear partial remainder, load iteration counter with WIDTH, enter BUSY.
REQ-017 BUSY: one restoring step per cycle -- shift {remainder, dividend} left by one, trial-subtract divisor from remainder, keep result and set quotient bit 1 if no borrow, else restore and set bit 0.
REQ-018 Trial subtraction SHALL be WIDTH+1 bits wide so remainder msb cannot overflow.
REQ-019 After WIDTH BUSY cycles, enter DONE; m_axis_dout_tvalid SHALL be high for exactly the DONE cycle, i.e. LATENCY cycles after the accept edge.
REQ-020 DONE SHALL return to IDLE unconditionally next edge; earliest next accept is LATENCY+1 cycles after prior accept.
REQ-021 Latency SHALL be fixed regardless of operand values; no early termination.
REQ-022 Divisor zero: quotient all ones, remainder equals dividend, divzero high; same latency.
REQ-023 tvalid asserted while BUSY or DONE SHALL be ignored and SHALL NOT corrupt captured operands.
REQ-024 Input tdata SHALL be sampled only at the accept edge; later changes have no effect.
REQ-025 m_axis_dout_tdata SHALL hold its last value outside DONE; consumers use it only with tvalid.
REQ-026 flush SHALL force IDLE next edge from any state; a flush in the DONE cycle does not retract that cycle's tvalid, but no later tvalid SHALL follow from the aborted operation.
REQ-027 flush and valid operands in the same IDLE cycle: flush wins; no accept.
REQ-028 Sign handling is out of scope; the caller negates operands and results.

Reset
REQ-029 On rst: state IDLE, s_axis_tready 1 after reset edge, m_axis_dout_tvalid 0, m_axis_dout_divzero 0, m_axis_dout_tdata 0, counter 0.
REQ-030 rst mid-operation SHALL discard the operation; no tvalid SHALL follow.
REQ-031 rst SHALL take priority over flush and accept.

Structure
REQ-032 State encoding and LATENCY constant SHALL live in the shared header next to the bus and funct definitions.
REQ-033 One combinational sub-module div_step (one restoring step: remainder, dividend, divisor in; next remainder, next dividend, quotient bit out).
REQ-034 Module SHALL be a drop-in replacement for the vendor divider port set used by the EX-stage multiply/divide unit.

Verification
REQ-035 100 / 7 accepted at cycle 0 -> tvalid at cycle 33 only, tdata {14, 2}, divzero 0.
REQ-036 0xFFFFFFFF / 1 -> {0xFFFFFFFF, 0}; 0x80000000 / 0xFFFFFFFF -> {0, 0x80000000}.
REQ-037 0x12345678 / 0 -> {0xFFFFFFFF, 0x12345678}, divzero 1, at cycle 33.
REQ-038 Accept 100/7, flush at cycle 10 -> no tvalid; tready 1 at cycle 11; 9/3 then accepted -> {3, 0} 33 cycles later.
REQ-039 Only dividend_tvalid high for 5 cycles -> no accept, tready stays 1; new valid pair during BUSY -> ignored, first result unchanged.
REQ-040 rst at cycle 20 of an operation -> no tvalid, all outputs at reset values, tready 1.
